amber_wb_arbiter: RTL and testbench
===================================

# amber_wb_arbiter

Two-requester controller that shares the Amber core's single 128-bit Wishbone master port between the instruction-fetch unit (m0) and the data/load-store unit (m1). It grants the bus round-robin, sequences each Wishbone cycle (cyc/stb until ack or err), and ends hung cycles with a bus-timeout error. It sits between the core's internal ports and the external Wishbone bus driven by the GUVM bench.

## Interface
Parameters:
- TIMEOUT, 255: cycles without ack/err before the arbiter ends the cycle with an error; legal range 1..1023.
- M0_FIRST, 1: after reset, m0 wins the first simultaneous request.

Ports (clock and reset first):
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_mN_req  in  1  request from master N (N = 0, 1); held until ack/err.
- i_mN_adr  in  32  byte address.
- i_mN_sel  in  16  byte lane select.
- i_mN_we  in  1  1 = write.
- i_mN_dat  in  128  write data.
- o_mN_ack  out  1  transfer done (combinational, only while N owns the bus).
- o_mN_err  out  1  transfer failed (bus error or timeout).
- o_mN_rdat  out  128  read data; equals i_wb_dat while N is granted, else 0.
- o_wb_adr  out  32, o_wb_sel  out  16, o_wb_we  out  1, o_wb_dat  out  128: registered bus request fields.
- o_wb_cyc  out  1, o_wb_stb  out  1: registered; always equal to each other.
- i_wb_dat  in  128, i_wb_ack  in  1, i_wb_err  in  1: slave response.

## Operation
- States: IDLE, BUS.
- IDLE: the arbiter samples the requests.
  - If exactly one request is high, that master wins.
  - If both are high, the master not granted last wins. The last-grant pointer resets to m1 when M0_FIRST=1, so m0 wins first.
  - On a win, the arbiter registers the winner's adr/sel/we/dat onto the o_wb_* fields, sets cyc/stb, loads owner, clears the timeout counter and moves to BUS.
  - With no request, the arbiter stays in IDLE. All o_wb_* outputs hold their last values except cyc/stb, which are 0.
- BUS: the owner's o_mN_ack = i_wb_ack & ~i_wb_err, and o_mN_err = i_wb_err | timeout_hit.
  - On ack, err or timeout_hit: clear cyc/stb, update the last-grant pointer, go to IDLE.
  - Otherwise the timeout counter increments.
- timeout_hit: counter == TIMEOUT-1 and no ack/err in that cycle. It raises o_mN_err for one cycle.
- Counter width is clog2(TIMEOUT+1); the counter saturates and never wraps.
- Simultaneous ack and err: err wins and ack is suppressed. Ack in the timeout cycle: ack wins and there is no error.
- The non-owner's ack/err/rdat outputs are 0 at all times.
- Owner drops req while in BUS: illegal. The cycle still completes, the ack pulse is still driven, and req is not re-sampled until IDLE.
- A request held after its ack is re-arbitrated in IDLE like any new request. Masters must deassert req on the edge after ack.
- Reset, including mid-BUS:
  - state = IDLE, cyc/stb = 0, adr/sel/we/dat = 0, counter = 0, pointer = m1 (M0_FIRST=1) or m0.
  - All mN outputs are 0.
  - An interrupted transfer gives no ack.

## Timing
- req high in cycle N (IDLE) -> cyc/stb high from cycle N+1.
- Zero-wait slave (ack tied high, as the bench does): ack is seen in N+1 and o_mN_ack is high in N+1. The bus is back in IDLE in N+2.
- Minimum cost is 2 cycles per transfer, with one dead cycle (cyc=0) between back-to-back transfers.
- Timeout with no ack: err is high in cycle N+TIMEOUT and cyc drops in N+TIMEOUT+1.
- Wait states are any cycles with stb=1 and ack=err=0. The bus fields stay stable through them.

## Structure
- Package amber_wb_pkg:
  - state enum (ARB_IDLE, ARB_BUS)
  - master id typedef (1 bit)
  - WB_ADR_W=32, WB_DAT_W=128, WB_SEL_W=16
  - default TIMEOUT constant
- Sub-module amber_wb_rr_grant: a combinational 2-way round-robin picker. Inputs are the two requests and the last grant; outputs are the winner and a valid bit.
- The top level holds the FSM, the bus registers, the counter and the response steering.

## Test plan
- m0 read, adr=0x0000_0100, sel=0xFFFF, zero-wait ack, i_wb_dat=96'hF0081003F0081003F0081003 followed by 32'hE3A0_0001 -> cyc high exactly 1 cycle; o_m0_ack high 1 cycle; o_m0_rdat = that value; o_m1_* = 0.
- m0 and m1 request together in every cycle for 4 transfers -> grant order m0, m1, m0, m1; each transfer 2 cycles; correct adr on o_wb_adr for each.
- m1 write, adr=0x200, dat=128'h1, ack held low, TIMEOUT=8 -> o_m1_err high in cycle 8 after stb rose; cyc low next cycle; no ack.
- i_wb_err and i_wb_ack high together on an m1 read -> o_m1_err=1, o_m1_ack=0; next grant goes to m0 if it is requesting.
- i_rst asserted in the second wait-state cycle of an m0 transfer -> next edge: cyc/stb=0, o_wb_adr=0, no ack. After release, m0 and m1 requesting together -> m0 granted first.
- Two back-to-back m1 transfers (req re-asserted) with 3 wait states each -> exactly one cyc=0 cycle between them; bus fields stable during wait states.

Source files
------------

// File: rtl/amber_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amber_wb_pkg
// Description : Shared types and constants for the Amber Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package amber_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 128;
    localparam int WB_SEL_W = 16;

    // Default number of ack-less bus cycles before the arbiter forces an error
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUS  = 1'b1
    } arb_state_t;

    typedef logic [0:0] master_id_t;

    localparam master_id_t c_MASTER_M0 = 1'b0;
    localparam master_id_t c_MASTER_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/amber_wb_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : amber_wb_rr_grant
// Description : Combinational two-way round-robin picker. A lone request wins
//               outright; on a tie the master not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module amber_wb_rr_grant
    import amber_wb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [0:0] i_last,
    output logic [0:0] o_winner,
    output logic       o_valid
);

    // Pick the winner; default to m0 so the output is defined with no request
    always_comb begin
        o_winner = c_MASTER_M0;
        o_valid  = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_winner = (i_last == c_MASTER_M0) ? c_MASTER_M1 : c_MASTER_M0;
        end else if (i_req1) begin
            o_winner = c_MASTER_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/amber_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : amber_wb_arbiter
// Description : Shares the single 128-bit Wishbone master port between the
//               instruction-fetch unit (m0) and the load/store unit (m1).
//               Round-robin grant, registered bus request, combinational
//               response steering and a saturating bus-timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
module amber_wb_arbiter
    import amber_wb_pkg::*;
#(
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int M0_FIRST = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,

    input  logic           i_m0_req,
    input  logic [31:0]    i_m0_adr,
    input  logic [15:0]    i_m0_sel,
    input  logic           i_m0_we,
    input  logic [127:0]   i_m0_dat,
    output logic           o_m0_ack,
    output logic           o_m0_err,
    output logic [127:0]   o_m0_rdat,

    input  logic           i_m1_req,
    input  logic [31:0]    i_m1_adr,
    input  logic [15:0]    i_m1_sel,
    input  logic           i_m1_we,
    input  logic [127:0]   i_m1_dat,
    output logic           o_m1_ack,
    output logic           o_m1_err,
    output logic [127:0]   o_m1_rdat,

    output logic [31:0]    o_wb_adr,
    output logic [15:0]    o_wb_sel,
    output logic           o_wb_we,
    output logic [127:0]   o_wb_dat,
    output logic           o_wb_cyc,
    output logic           o_wb_stb,
    input  logic [127:0]   i_wb_dat,
    input  logic           i_wb_ack,
    input  logic           i_wb_err
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    // Pointing at m1 after reset makes m0 win the first tie
    localparam master_id_t         c_LAST_RST = (M0_FIRST != 0) ? c_MASTER_M1 : c_MASTER_M0;

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    master_id_t             r_owner;
    master_id_t             r_last;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [WB_ADR_W-1:0]    r_adr;
    logic [WB_SEL_W-1:0]    r_sel;
    logic                   r_we;
    logic [WB_DAT_W-1:0]    r_dat;
    logic                   r_cyc;

    logic [0:0]             w_winner;
    logic                   w_valid;
    logic                   w_in_bus;
    logic                   w_win;
    logic                   w_timeout_hit;
    logic                   w_done;
    logic                   w_live;
    logic                   w_own0;
    logic                   w_own1;

    logic [WB_ADR_W-1:0]    w_req_adr;
    logic [WB_SEL_W-1:0]    w_req_sel;
    logic                   w_req_we;
    logic [WB_DAT_W-1:0]    w_req_dat;

    amber_wb_rr_grant u_rr_grant (
        .i_req0   (i_m0_req),
        .i_req1   (i_m1_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Cycle-level status: a win in IDLE, a timeout, and end of the bus cycle
    always_comb begin
        w_in_bus      = (r_state == ARB_BUS);
        w_win         = (r_state == ARB_IDLE) && w_valid;
        // Ack or err in the final counted cycle takes precedence over timeout
        w_timeout_hit = w_in_bus && (r_cnt == c_TO_LAST) && !i_wb_ack && !i_wb_err;
        w_done        = w_in_bus && (i_wb_ack || i_wb_err || w_timeout_hit);
    end

    // Select the winning master's request fields for registering
    always_comb begin
        w_req_adr = i_m0_adr;
        w_req_sel = i_m0_sel;
        w_req_we  = i_m0_we;
        w_req_dat = i_m0_dat;
        if (w_winner == c_MASTER_M1) begin
            w_req_adr = i_m1_adr;
            w_req_sel = i_m1_sel;
            w_req_we  = i_m1_we;
            w_req_dat = i_m1_dat;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: requests are only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: if (w_valid) w_next_state = ARB_BUS;
            ARB_BUS:  if (w_done)  w_next_state = ARB_IDLE;
            default:  w_next_state = ARB_IDLE;
        endcase
    end

    // Bus request registers: loaded on a win, held otherwise; cyc/stb drop at end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_adr <= '0;
            r_sel <= '0;
            r_we  <= 1'b0;
            r_dat <= '0;
            r_cyc <= 1'b0;
        end else if (w_win) begin
            r_adr <= w_req_adr;
            r_sel <= w_req_sel;
            r_we  <= w_req_we;
            r_dat <= w_req_dat;
            r_cyc <= 1'b1;
        end else if (w_done) begin
            r_cyc <= 1'b0;
        end
    end

    // Owner is captured on a win; the fairness pointer moves when the cycle ends
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= c_MASTER_M0;
            r_last  <= c_LAST_RST;
        end else begin
            if (w_win) begin
                r_owner <= w_winner;
            end
            if (w_done) begin
                r_last <= r_owner;
            end
        end
    end

    // Timeout counter: cleared on a win, counts ack-less bus cycles, saturates
    always_ff @(posedge i_clk) begin
        if (i_rst || w_win) begin
            r_cnt <= '0;
        end else if (w_in_bus && !w_done && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Response steering: only the owner sees the slave, and never while in reset
    always_comb begin
        w_live    = w_in_bus && !i_rst;
        w_own0    = w_live && (r_owner == c_MASTER_M0);
        w_own1    = w_live && (r_owner == c_MASTER_M1);
        o_m0_ack  = w_own0 && i_wb_ack && !i_wb_err;
        o_m0_err  = w_own0 && (i_wb_err || w_timeout_hit);
        o_m0_rdat = w_own0 ? i_wb_dat : '0;
        o_m1_ack  = w_own1 && i_wb_ack && !i_wb_err;
        o_m1_err  = w_own1 && (i_wb_err || w_timeout_hit);
        o_m1_rdat = w_own1 ? i_wb_dat : '0;
    end

    assign o_wb_adr = r_adr;
    assign o_wb_sel = r_sel;
    assign o_wb_we  = r_we;
    assign o_wb_dat = r_dat;
    assign o_wb_cyc = r_cyc;
    assign o_wb_stb = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_amber_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_amber_wb_arbiter
// Description : Scoreboard bench for amber_wb_arbiter. Stimulus pushes the
//               expected bus requests and master responses; a monitor pops
//               and compares whenever cyc rises or a response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amber_wb_arbiter;

    localparam int TO = 8;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic         we;
        logic [127:0] dat;
    } req_t;

    typedef struct {
        logic         m;
        logic         err;
        logic         chk_rdat;
        logic [127:0] rdat;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0]  m0_adr = '0, m1_adr = '0;
    logic [15:0]  m0_sel = '0, m1_sel = '0;
    logic         m0_we = 1'b0, m1_we = 1'b0;
    logic [127:0] m0_dat = '0, m1_dat = '0;
    logic         m0_ack, m0_err, m1_ack, m1_err;
    logic [127:0] m0_rdat, m1_rdat;
    logic [31:0]  wb_adr;
    logic [15:0]  wb_sel;
    logic         wb_we, wb_cyc, wb_stb;
    logic [127:0] wb_dat;
    logic [127:0] wb_rdat;
    logic         wb_ack = 1'b0, wb_err = 1'b0;

    // slave model controls
    int           slave_wait    = 0;
    logic         slave_hang    = 1'b0;
    logic [31:0]  slave_err_adr = 32'hFFFF_FFFF;
    logic [127:0] slave_rdat    = '0;
    int           wcnt          = 0;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc_cycles = 0;
    req_t         exp_req_q[$];
    rsp_t         exp_rsp_q[$];

    assign wb_rdat = slave_rdat;

    amber_wb_arbiter #(.TIMEOUT(TO), .M0_FIRST(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_m0_req  (m0_req),
        .i_m0_adr  (m0_adr),
        .i_m0_sel  (m0_sel),
        .i_m0_we   (m0_we),
        .i_m0_dat  (m0_dat),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .o_m0_rdat (m0_rdat),
        .i_m1_req  (m1_req),
        .i_m1_adr  (m1_adr),
        .i_m1_sel  (m1_sel),
        .i_m1_we   (m1_we),
        .i_m1_dat  (m1_dat),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_m1_rdat (m1_rdat),
        .o_wb_adr  (wb_adr),
        .o_wb_sel  (wb_sel),
        .o_wb_we   (wb_we),
        .o_wb_dat  (wb_dat),
        .o_wb_cyc  (wb_cyc),
        .o_wb_stb  (wb_stb),
        .i_wb_dat  (wb_rdat),
        .i_wb_ack  (wb_ack),
        .i_wb_err  (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_req(input logic [31:0] a, input logic [15:0] s, input logic w, input logic [127:0] d);
        req_t r;
        r.adr = a; r.sel = s; r.we = w; r.dat = d;
        exp_req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic m, input logic e, input logic c, input logic [127:0] d);
        rsp_t r;
        r.m = m; r.err = e; r.chk_rdat = c; r.rdat = d;
        exp_rsp_q.push_back(r);
    endtask

    // Slave: acks after slave_wait wait states, errs on slave_err_adr, or hangs
    always @(negedge clk) begin
        if (wb_cyc) begin
            if (slave_hang) begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
            end else if (wcnt >= slave_wait) begin
                wb_ack = 1'b1;
                wb_err = (wb_adr == slave_err_adr);
            end else begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
                wcnt++;
            end
        end else begin
            wb_ack = 1'b0;
            wb_err = 1'b0;
            wcnt   = 0;
        end
    end

    // Monitor: checks request fields when cyc rises, stability while it stays
    // high, and every master response against the scoreboard queue
    logic  prev_cyc = 1'b0;
    req_t  snap;
    always begin
        @(negedge clk);
        #2;
        if (wb_cyc) cyc_cycles++;
        if (wb_cyc !== wb_stb) check("cyc_eq_stb", {127'b0, wb_stb}, {127'b0, wb_cyc});
        if (wb_cyc && !prev_cyc) begin
            if (exp_req_q.size() == 0) begin
                check("unexpected_bus_cycle", {96'b0, wb_adr}, 128'b0);
            end else begin
                req_t e;
                e = exp_req_q.pop_front();
                check("req_adr", {96'b0, wb_adr}, {96'b0, e.adr});
                check("req_sel", {112'b0, wb_sel}, {112'b0, e.sel});
                check("req_we",  {127'b0, wb_we}, {127'b0, e.we});
                check("req_dat", wb_dat, e.dat);
            end
            snap.adr = wb_adr; snap.sel = wb_sel; snap.we = wb_we; snap.dat = wb_dat;
        end else if (wb_cyc && prev_cyc) begin
            check("stable_adr", {96'b0, wb_adr}, {96'b0, snap.adr});
            check("stable_dat", wb_dat, snap.dat);
        end
        prev_cyc = wb_cyc;

        if (m0_ack || m0_err || m1_ack || m1_err) begin
            if (exp_rsp_q.size() == 0) begin
                check("unexpected_rsp", {124'b0, m1_ack, m1_err, m0_ack, m0_err}, 128'b0);
            end else begin
                rsp_t e;
                logic m;
                logic er;
                e  = exp_rsp_q.pop_front();
                m  = m1_ack | m1_err;
                er = m ? m1_err : m0_err;
                check("rsp_master", {127'b0, m}, {127'b0, e.m});
                check("rsp_err", {127'b0, er}, {127'b0, e.err});
                check("rsp_ack", {127'b0, (m ? m1_ack : m0_ack)}, {127'b0, ~e.err});
                if (e.chk_rdat) check("rsp_rdat", m ? m1_rdat : m0_rdat, e.rdat);
                if (e.m) check("m0_quiet", {m0_rdat[125:0], m0_ack, m0_err}, 128'b0);
                else     check("m1_quiet", {m1_rdat[125:0], m1_ack, m1_err}, 128'b0);
            end
        end
    end

    // Global time limit so the bench always reaches its summary line
    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int base;
        int found;

        // reset state
        idle(3);
        check("rst_cyc", {127'b0, wb_cyc}, 128'b0);
        check("rst_stb", {127'b0, wb_stb}, 128'b0);
        check("rst_adr", {96'b0, wb_adr}, 128'b0);
        check("rst_sel_we", {111'b0, wb_sel, wb_we}, 128'b0);
        check("rst_dat", wb_dat, 128'b0);
        check("rst_m_out", {m0_rdat[63:0], m1_rdat[59:0], m0_ack, m0_err, m1_ack, m1_err}, 128'b0);
        rst = 1'b0;
        idle(2);

        // m0 vs m1 every cycle for 4 transfers: m0, m1, m0, m1
        m0_adr = 32'h0000_1000; m0_sel = 16'hFFFF; m0_we = 1'b0;
        m1_adr = 32'h0000_2000; m1_sel = 16'h00FF; m1_we = 1'b1; m1_dat = 128'hA5;
        slave_rdat = 128'h1234;
        for (int i = 0; i < 2; i++) begin
            push_req(32'h0000_1000, 16'hFFFF, 1'b0, 128'h0);
            push_rsp(1'b0, 1'b0, 1'b1, 128'h1234);
            push_req(32'h0000_2000, 16'h00FF, 1'b1, 128'hA5);
            push_rsp(1'b1, 1'b0, 1'b0, 128'h0);
        end
        base = cyc_cycles;
        m0_req = 1'b1; m1_req = 1'b1;
        idle(8);
        m0_req = 1'b0; m1_req = 1'b0;
        idle(3);
        check("rr_cyc_cycles", 128'(cyc_cycles - base), 128'd4);

        // m0 zero-wait read
        slave_rdat = 128'hF0081003F0081003F0081003E3A00001;
        m0_adr = 32'h0000_0100; m0_sel = 16'hFFFF; m0_we = 1'b0; m0_dat = '0;
        push_req(32'h0000_0100, 16'hFFFF, 1'b0, 128'h0);
        push_rsp(1'b0, 1'b0, 1'b1, 128'hF0081003F0081003F0081003E3A00001);
        base = cyc_cycles;
        m0_req = 1'b1;
        idle(2);
        m0_req = 1'b0;
        idle(3);
        check("m0_read_cyc_cycles", 128'(cyc_cycles - base), 128'd1);

        // m1 write with hung slave -> timeout error in cycle N+TO
        slave_hang = 1'b1;
        m1_adr = 32'h0000_0200; m1_sel = 16'hFFFF; m1_we = 1'b1; m1_dat = 128'h1;
        push_req(32'h0000_0200, 16'hFFFF, 1'b1, 128'h1);
        push_rsp(1'b1, 1'b1, 1'b0, 128'h0);
        m1_req = 1'b1;
        found = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #2;
            if (m1_err) begin
                found = k;
                break;
            end
        end
        check("timeout_cycle", 128'(found), 128'(TO));
        tick();
        m1_req = 1'b0;
        check("timeout_cyc_drop", {127'b0, wb_cyc}, 128'b0);
        slave_hang = 1'b0;
        idle(2);

        // ack and err together on m1 read; m0 then wins the tie
        slave_err_adr = 32'h0000_0400;
        slave_rdat    = 128'h55;
        m1_adr = 32'h0000_0400; m1_sel = 16'h000F; m1_we = 1'b0; m1_dat = '0;
        m0_adr = 32'h0000_0410; m0_sel = 16'hF000; m0_we = 1'b0;
        push_req(32'h0000_0400, 16'h000F, 1'b0, 128'h0);
        push_rsp(1'b1, 1'b1, 1'b0, 128'h0);
        push_req(32'h0000_0410, 16'hF000, 1'b0, 128'h0);
        push_rsp(1'b0, 1'b0, 1'b1, 128'h55);
        m1_req = 1'b1;
        tick();
        m0_req = 1'b1;
        idle(3);
        m0_req = 1'b0; m1_req = 1'b0;
        slave_err_adr = 32'hFFFF_FFFF;
        idle(2);

        // reset in the second wait state of an m0 transfer
        slave_wait = 3;
        m0_adr = 32'h0000_0500; m0_sel = 16'hFFFF; m0_we = 1'b0;
        push_req(32'h0000_0500, 16'hFFFF, 1'b0, 128'h0);
        m0_req = 1'b1;
        idle(2);
        rst = 1'b1;
        m0_req = 1'b0;
        tick();
        check("midrst_cyc", {126'b0, wb_cyc, wb_stb}, 128'b0);
        check("midrst_adr", {96'b0, wb_adr}, 128'b0);
        check("midrst_ack", {126'b0, m0_ack, m0_err}, 128'b0);
        rst = 1'b0;
        slave_wait = 0;
        slave_rdat = 128'h77;
        m0_adr = 32'h0000_0600; m0_sel = 16'h0F0F;
        m1_adr = 32'h0000_0700; m1_sel = 16'hF0F0; m1_we = 1'b0;
        push_req(32'h0000_0600, 16'h0F0F, 1'b0, 128'h0);
        push_rsp(1'b0, 1'b0, 1'b1, 128'h77);
        push_req(32'h0000_0700, 16'hF0F0, 1'b0, 128'h0);
        push_rsp(1'b1, 1'b0, 1'b1, 128'h77);
        m0_req = 1'b1; m1_req = 1'b1;
        idle(4);
        m0_req = 1'b0; m1_req = 1'b0;
        idle(2);

        // two back-to-back m1 reads with 3 wait states each
        slave_wait = 3;
        slave_rdat = 128'h99;
        m1_adr = 32'h0000_0300; m1_sel = 16'hFFFF; m1_we = 1'b0;
        push_req(32'h0000_0300, 16'hFFFF, 1'b0, 128'h0);
        push_rsp(1'b1, 1'b0, 1'b1, 128'h99);
        push_req(32'h0000_0304, 16'hFFFF, 1'b0, 128'h0);
        push_rsp(1'b1, 1'b0, 1'b1, 128'h99);
        base = cyc_cycles;
        m1_req = 1'b1;
        idle(5);
        check("b2b_gap_cyc", {127'b0, wb_cyc}, 128'b0);
        m1_adr = 32'h0000_0304;
        tick();
        check("b2b_second_cyc", {127'b0, wb_cyc}, 128'b1);
        idle(4);
        m1_req = 1'b0;
        check("b2b_end_cyc", {127'b0, wb_cyc}, 128'b0);
        idle(3);
        check("b2b_cyc_cycles", 128'(cyc_cycles - base), 128'd8);

        check("req_queue_empty", 128'(exp_req_q.size()), 128'd0);
        check("rsp_queue_empty", 128'(exp_rsp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
